ex_result_stage: RTL and testbench

// - Execute-stage output register; sits directly downstream of the shifter and ALU.
// - Selects shifter or ALU result by ALU op and bundles it with destination/memory control.
// - Presents the bundle to MEM through a 2-entry valid/ready skid buffer, so EX is never

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/skid_buffer2.sv | 104 ++++++++++
 rtl/ex_result_stage.sv | 87 ++++++++
 tb/tb_ex_result_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the execute stage and its neighbours.
//   XLEN / REG_AW : datapath and register-file address widths
//   alu_op_e      : ALU/shifter op codes (shifts are 2, 6, 7)
//   ex_bundle_t   : result bundle handed from EX to MEM
//   skid_state_e  : occupancy of the 2-entry skid buffer
//   is_shift_op() : true when the op's result comes from the shifter
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [REG_AW-1:0] rd;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic [XLEN-1:0]   store_data;
    } ex_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Unused / invalid codes fall through to the ALU result.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready skid buffer carrying an opaque W-bit payload.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous squash of held and incoming entries
//   in_valid/in_ready   : upstream handshake (in_ready is a flop)
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake
//   out_data            : head payload
//   state_dbg           : current occupancy (skid_state_e encoding)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; the sender holds its payload stable while valid is high and ready low.
module skid_buffer2
    import cpu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   state_dbg
);

    skid_state_e  state_q, state_d;
    logic         in_ready_q;
    logic [W-1:0] head_q, skid_q;

    logic accept, pop;
    logic load_head_in, load_head_skid, load_skid_in;

    assign accept    = in_valid & in_ready_q;
    assign pop       = (state_q != EMPTY) & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    state_d      = TWO;
                    load_skid_in = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so accept cannot occur.
                if (pop) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any concurrent accept or pop.
        if (flush) begin
            state_d        = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            // Registered ready: computed from the next state, so it is a flop output.
            in_ready_q <= (state_d != TWO);
            if (load_head_in) begin
                head_q <= in_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage output register. Picks the shifter or ALU result by op code,
// bundles it with destination/memory control, and hands it to MEM through a
// 2-entry skid buffer so EX is never combinationally stalled by MEM. The head
// entry is also exported as a forwarding source for the operand muxes.
//   in_valid/in_ready    : EX handshake (in_ready registered)
//   ALU_op, alu_result,
//   shift_result         : result select inputs
//   rd_addr, reg_wr,
//   mem_rd, mem_wr,
//   store_data           : destination / memory control
//   flush                : squash all held and incoming entries
//   out_valid/out_ready  : MEM handshake
//   out_*                : head bundle
//   fwd_valid/rd/data    : forwarding view of the head
module ex_result_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ALU_op,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   shift_result,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_wr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [XLEN-1:0]   store_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_wr,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [XLEN-1:0]   out_store_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
);

    localparam int BW = $bits(ex_bundle_t);

    ex_bundle_t    in_bundle, head;
    logic [BW-1:0] head_raw;
    logic [1:0]    sb_state;

    always_comb begin
        in_bundle            = '0;
        in_bundle.result     = is_shift_op(ALU_op) ? shift_result : alu_result;
        in_bundle.rd         = rd_addr;
        // x0 is hardwired; never advertise it as a write target.
        in_bundle.reg_wr     = reg_wr & (rd_addr != '0);
        in_bundle.mem_rd     = mem_rd;
        in_bundle.mem_wr     = mem_wr;
        in_bundle.store_data = store_data;
    end

    skid_buffer2 #(.W(BW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_raw),
        .state_dbg (sb_state)
    );

    assign head           = head_raw;
    assign out_result     = head.result;
    assign out_rd         = head.rd;
    assign out_reg_wr     = head.reg_wr;
    assign out_mem_rd     = head.mem_rd;
    assign out_mem_wr     = head.mem_wr;
    assign out_store_data = head.store_data;

    // Load results are only an address here; the data arrives later from MEM.
    assign fwd_valid = (sb_state != 2'(EMPTY)) & head.reg_wr & ~head.mem_rd;
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.result;

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_op;
    logic [31:0] alu_result, shift_result, store_data;
    logic [4:0]  rd_addr;
    logic        reg_wr, mem_rd, mem_wr, flush;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data, fwd_data;
    logic [4:0]  out_rd, fwd_rd;
    logic        out_reg_wr, out_mem_rd, out_mem_wr, fwd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected bundle packed as {result, rd, reg_wr, mem_rd, mem_wr, store_data}.
    logic [71:0] exp_q[$];

    ex_result_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_op(ALU_op), .alu_result(alu_result), .shift_result(shift_result),
        .rd_addr(rd_addr), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_data(store_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_reg_wr(out_reg_wr),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_store_data(out_store_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] alu,
                          input logic [31:0] sh, input logic [4:0] rd, input logic wr,
                          input logic mrd, input logic mwr, input logic [31:0] sd);
        in_valid     = v;
        ALU_op       = op;
        alu_result   = alu;
        shift_result = sh;
        rd_addr      = rd;
        reg_wr       = wr;
        mem_rd       = mrd;
        mem_wr       = mwr;
        store_data   = sd;
    endtask

    task automatic idle_in();
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Reference model for one bundle, written from the behavioural description.
    function automatic logic [71:0] model(input logic [3:0] op, input logic [31:0] alu,
                                          input logic [31:0] sh, input logic [4:0] rd,
                                          input logic wr, input logic mrd, input logic mwr,
                                          input logic [31:0] sd);
        logic [31:0] res;
        res = (op == 4'd2 || op == 4'd6 || op == 4'd7) ? sh : alu;
        return {res, rd, wr && (rd != 5'd0), mrd, mwr, sd};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        int sent;
        logic [71:0] e;
        logic [71:0] obs;
        logic took;

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        idle_in();
        #12;
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd",    out_rd, 0);
        check("rst_ctrl",      {out_reg_wr, out_mem_rd, out_mem_wr}, 0);
        check("rst_fwd",       {fwd_valid, fwd_rd, fwd_data}, 0);
        rst_n = 1'b1;
        step();

        // Pass-through: SLL picks the shifter result.
        out_ready = 1'b1;
        set_in(1, 4'd2, 32'h1, 32'h0000_0F00, 5'd5, 1, 0, 0, 32'd0);
        step();
        idle_in();
        check("pt_valid",  out_valid, 1);
        check("pt_result", out_result, 32'h0F00);
        check("pt_rd",     out_rd, 5);
        check("pt_fwd",    {fwd_valid, fwd_rd, fwd_data}, {1'b1, 5'd5, 32'h0F00});
        step();
        check("pt_drain", out_valid, 0);

        // SRA and an invalid op.
        set_in(1, 4'd7, 32'h1234, 32'hFFFF_FFF0, 5'd3, 1, 0, 0, 32'd0);
        step();
        check("sra_result", out_result, 32'hFFFF_FFF0);
        set_in(1, 4'd15, 32'h5555, 32'hAAAA, 5'd3, 1, 0, 0, 32'd0);
        step();
        check("badop_result", out_result, 32'h5555);
        idle_in();
        step();

        // Back-pressure: three bundles against a stalled MEM.
        out_ready = 1'b0;
        set_in(1, 4'd0, 32'hA, 32'h0, 5'd1, 1, 0, 0, 32'd0);
        step();
        check("bp_rdy1", in_ready, 1);
        set_in(1, 4'd0, 32'hB, 32'h0, 5'd1, 1, 0, 0, 32'd0);
        step();
        check("bp_rdy2", in_ready, 0);
        set_in(1, 4'd0, 32'hC, 32'h0, 5'd1, 1, 0, 0, 32'd0);
        step();
        check("bp_hold", {out_valid, in_ready, out_result}, {1'b1, 1'b0, 32'hA});
        out_ready = 1'b1;
        #1;
        check("bp_out_a", out_result, 32'hA);
        step();
        check("bp_out_b", out_result, 32'hB);
        step();
        idle_in();
        check("bp_out_c", {out_valid, out_result}, {1'b1, 32'hC});
        step();
        check("bp_empty", out_valid, 0);

        // Flush while TWO, with an incoming bundle in the flush cycle.
        out_ready = 1'b0;
        set_in(1, 4'd0, 32'h11, 32'h0, 5'd2, 1, 0, 0, 32'd0);
        step();
        set_in(1, 4'd0, 32'h22, 32'h0, 5'd2, 1, 0, 0, 32'd0);
        step();
        check("fl_two", in_ready, 0);
        step();
        set_in(1, 4'd0, 32'h77, 32'h0, 5'd2, 1, 0, 0, 32'd0);
        flush = 1'b1;
        step();
        check("fl_state", {out_valid, in_ready}, {1'b0, 1'b1});
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        step();
        check("fl_absent", out_valid, 0);

        // Load / x0 / store.
        out_ready = 1'b1;
        set_in(1, 4'd0, 32'h100, 32'h0, 5'd7, 1, 1, 0, 32'd0);
        step();
        check("ld_fwd", {out_valid, out_mem_rd, out_reg_wr, fwd_valid}, 4'b1110);
        set_in(1, 4'd0, 32'h200, 32'h0, 5'd0, 1, 0, 0, 32'd0);
        step();
        check("x0_regwr", {out_valid, out_reg_wr, fwd_valid}, 3'b100);
        set_in(1, 4'd0, 32'h300, 32'h0, 5'd9, 0, 0, 1, 32'hCAFE_F00D);
        step();
        idle_in();
        check("st_bundle", {out_mem_wr, out_store_data, out_result, fwd_valid},
              {1'b1, 32'hCAFE_F00D, 32'h300, 1'b0});
        step();

        // Async reset while TWO.
        out_ready = 1'b0;
        set_in(1, 4'd0, 32'h31, 32'h0, 5'd4, 1, 0, 0, 32'd0);
        step();
        set_in(1, 4'd0, 32'h32, 32'h0, 5'd4, 1, 0, 0, 32'd0);
        step();
        idle_in();
        check("ar_two", {out_valid, in_ready}, {1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_now", {out_valid, in_ready, out_result, out_rd, fwd_valid},
              {1'b1 ^ 1'b1, 1'b1, 32'd0, 5'd0, 1'b0});
        step();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("ar_rel", {out_valid, in_ready}, {1'b0, 1'b1});
        step();
        check("ar_stale", out_valid, 0);

        // Random valid/ready with scoreboard.
        cycles = 0;
        sent = 0;
        while ((sent < 10000 || exp_q.size() > 0 || in_valid) && cycles < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
                set_in(1, 4'($urandom_range(0, 15)), $urandom, $urandom,
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            #1;
            if (out_valid && out_ready) begin
                obs = {out_result, out_rd, out_reg_wr, out_mem_rd, out_mem_wr, out_store_data};
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", obs, 72'd0 ^ ~obs);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_bundle", obs, e);
                    check("sb_fwd", fwd_valid, e[34] & ~e[33]);
                end
            end
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back(model(ALU_op, alu_result, shift_result, rd_addr,
                                      reg_wr, mem_rd, mem_wr, store_data));
                sent++;
            end
            step();
            if (took) idle_in();
            cycles++;
        end
        check("sb_sent", sent, 10000);
        check("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
